// File: rtl/gate_resp_checker_if.sv
// rtl/gate_resp_checker_if.sv - sample handshake between a gate bench and the response checker
//
// Purpose: carries one sampled (a, b, c) triple per handshake.
// Signals:
//   in_valid  master->slave  sample triple valid
//   in_ready  slave->master  checker accepts a sample this cycle
//   in_a      master->slave  gate input a as driven
//   in_b      master->slave  gate input b as driven
//   in_c      master->slave  gate output c as observed
interface gate_resp_checker_if;
   logic in_valid;
   logic in_ready;
   logic in_a;
   logic in_b;
   logic in_c;

   modport master (output in_valid, output in_a, output in_b, output in_c, input in_ready);
   modport slave  (input in_valid, input in_a, input in_b, input in_c, output in_ready);
endinterface

// File: rtl/gate_resp_checker.sv
// rtl/gate_resp_checker.sv - truth-table response checker for a 2-input gate under test
//
// Purpose: accepts sampled (a, b, c) triples, compares c against the expected
// output of the selected gate, counts vectors and mismatches, tracks input
// coverage and reports done/pass after NUM_VEC vectors.
// Parameters:
//   GATE_OP  0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6-7 OR
//   NUM_VEC  vectors per run (1 .. 2^CNT_W-1)
//   CNT_W    width of err_cnt / vec_cnt
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        one-cycle pulse, starts a run from IDLE or DONE
//   s_if         sample handshake (in_valid/in_ready/in_a/in_b/in_c)
//   busy, done   state indications (RUN, DONE)
//   pass         no mismatches and full coverage, valid while done
//   err_cnt      saturating mismatch count
//   vec_cnt      accepted vector count
//   cov          bit {a,b} set once that combination has been accepted
// Optional (macro GATE_RESP_FIRST_ERR_EN):
//   first_err_vld, first_err  capture {a,b,c} of the first mismatch of a run
module gate_resp_checker #(
   parameter int unsigned GATE_OP = 1,
   parameter int unsigned NUM_VEC = 4,
   parameter int unsigned CNT_W   = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   gate_resp_checker_if.slave s_if,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [CNT_W-1:0]   err_cnt,
   output logic [CNT_W-1:0]   vec_cnt,
   output logic [3:0]         cov
`ifdef GATE_RESP_FIRST_ERR_EN
   ,
   output logic               first_err_vld,
   output logic [2:0]         first_err
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] NUM_VEC_C = CNT_W'(NUM_VEC);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
   logic [3:0]       cov_q, cov_d;
   logic             pass_q, pass_d;
   logic             exp_c;
   logic             hs;
`ifdef GATE_RESP_FIRST_ERR_EN
   logic             first_err_vld_q, first_err_vld_d;
   logic [2:0]       first_err_q, first_err_d;
`endif

   // Expected gate output; undefined opcodes fall back to OR.
   always_comb begin
      exp_c = s_if.in_a | s_if.in_b;
      case (GATE_OP)
         0:       exp_c = s_if.in_a & s_if.in_b;
         1:       exp_c = s_if.in_a | s_if.in_b;
         2:       exp_c = s_if.in_a ^ s_if.in_b;
         3:       exp_c = ~(s_if.in_a & s_if.in_b);
         4:       exp_c = ~(s_if.in_a | s_if.in_b);
         5:       exp_c = ~(s_if.in_a ^ s_if.in_b);
         default: exp_c = s_if.in_a | s_if.in_b;
      endcase
   end

   assign s_if.in_ready = (state_q == RUN);
   assign hs            = (state_q == RUN) && s_if.in_valid;

   always_comb begin
      state_d   = state_q;
      err_cnt_d = err_cnt_q;
      vec_cnt_d = vec_cnt_q;
      cov_d     = cov_q;
      pass_d    = pass_q;
`ifdef GATE_RESP_FIRST_ERR_EN
      first_err_vld_d = first_err_vld_q;
      first_err_d     = first_err_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d   = RUN;
               err_cnt_d = '0;
               vec_cnt_d = '0;
               cov_d     = 4'h0;
               pass_d    = 1'b0;
`ifdef GATE_RESP_FIRST_ERR_EN
               first_err_vld_d = 1'b0;
               first_err_d     = 3'b000;
`endif
            end
         end
         RUN: begin
            if (hs) begin
               if (s_if.in_c != exp_c) begin
                  if (err_cnt_q != {CNT_W{1'b1}}) begin
                     err_cnt_d = err_cnt_q + CNT_W'(1);
                  end
`ifdef GATE_RESP_FIRST_ERR_EN
                  if (!first_err_vld_q) begin
                     first_err_vld_d = 1'b1;
                     first_err_d     = {s_if.in_a, s_if.in_b, s_if.in_c};
                  end
`endif
               end
               vec_cnt_d                      = vec_cnt_q + CNT_W'(1);
               cov_d[{s_if.in_a, s_if.in_b}] = 1'b1;
               // Final vector: leave RUN on the same edge so no extra sample is accepted.
               if (vec_cnt_d == NUM_VEC_C) begin
                  state_d = DONE;
                  pass_d  = (err_cnt_d == '0) && (cov_d == 4'hF);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         err_cnt_q <= '0;
         vec_cnt_q <= '0;
         cov_q     <= 4'h0;
         pass_q    <= 1'b0;
`ifdef GATE_RESP_FIRST_ERR_EN
         first_err_vld_q <= 1'b0;
         first_err_q     <= 3'b000;
`endif
      end else begin
         state_q   <= state_d;
         err_cnt_q <= err_cnt_d;
         vec_cnt_q <= vec_cnt_d;
         cov_q     <= cov_d;
         pass_q    <= pass_d;
`ifdef GATE_RESP_FIRST_ERR_EN
         first_err_vld_q <= first_err_vld_d;
         first_err_q     <= first_err_d;
`endif
      end
   end

   assign busy    = (state_q == RUN);
   assign done    = (state_q == DONE);
   assign pass    = pass_q;
   assign err_cnt = err_cnt_q;
   assign vec_cnt = vec_cnt_q;
   assign cov     = cov_q;
`ifdef GATE_RESP_FIRST_ERR_EN
   assign first_err_vld = first_err_vld_q;
   assign first_err     = first_err_q;
`endif

endmodule

// File: tb/tb_gate_resp_checker.sv
// tb/tb_gate_resp_checker.sv - directed self-checking bench for gate_resp_checker
module tb_gate_resp_checker;

   logic clk;
   logic rst_n;
   logic start0, start1, start2;
   logic tb_valid, tb_a, tb_b, tb_c;

   int n_checks;
   int n_errors;

   // dut0: OR, 4 vectors, 8-bit counters
   logic       busy0, done0, pass0;
   logic [7:0] err0, vec0;
   logic [3:0] cov0;
   // dut1: AND, 4 vectors
   logic       busy1, done1, pass1;
   logic [7:0] err1, vec1;
   logic [3:0] cov1;
   // dut2: OR, 3 vectors, 2-bit counters
   logic       busy2, done2, pass2;
   logic [1:0] err2, vec2;
   logic [3:0] cov2;
`ifdef GATE_RESP_FIRST_ERR_EN
   logic       fev0, fev1, fev2;
   logic [2:0] fe0, fe1, fe2;
`endif

   gate_resp_checker_if if0 ();
   gate_resp_checker_if if1 ();
   gate_resp_checker_if if2 ();

   // All three checkers see the same sample stream; only the one that was started reacts.
   assign if0.in_valid = tb_valid;
   assign if0.in_a     = tb_a;
   assign if0.in_b     = tb_b;
   assign if0.in_c     = tb_c;
   assign if1.in_valid = tb_valid;
   assign if1.in_a     = tb_a;
   assign if1.in_b     = tb_b;
   assign if1.in_c     = tb_c;
   assign if2.in_valid = tb_valid;
   assign if2.in_a     = tb_a;
   assign if2.in_b     = tb_b;
   assign if2.in_c     = tb_c;

   gate_resp_checker #(.GATE_OP(1), .NUM_VEC(4), .CNT_W(8)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .s_if(if0),
      .busy(busy0), .done(done0), .pass(pass0),
      .err_cnt(err0), .vec_cnt(vec0), .cov(cov0)
`ifdef GATE_RESP_FIRST_ERR_EN
      , .first_err_vld(fev0), .first_err(fe0)
`endif
   );

   gate_resp_checker #(.GATE_OP(0), .NUM_VEC(4), .CNT_W(8)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .s_if(if1),
      .busy(busy1), .done(done1), .pass(pass1),
      .err_cnt(err1), .vec_cnt(vec1), .cov(cov1)
`ifdef GATE_RESP_FIRST_ERR_EN
      , .first_err_vld(fev1), .first_err(fe1)
`endif
   );

   gate_resp_checker #(.GATE_OP(1), .NUM_VEC(3), .CNT_W(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .s_if(if2),
      .busy(busy2), .done(done2), .pass(pass2),
      .err_cnt(err2), .vec_cnt(vec2), .cov(cov2)
`ifdef GATE_RESP_FIRST_ERR_EN
      , .first_err_vld(fev2), .first_err(fe2)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One-cycle valid pulse; returns at the falling edge after the accepting edge.
   task automatic send_vec(input logic a, input logic b, input logic c);
      @(negedge clk);
      tb_valid = 1'b1;
      tb_a = a;
      tb_b = b;
      tb_c = c;
      @(negedge clk);
      tb_valid = 1'b0;
   endtask

   task automatic gap(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start(input int which);
      @(negedge clk);
      if (which == 0) start0 = 1'b1;
      if (which == 1) start1 = 1'b1;
      if (which == 2) start2 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      start1 = 1'b0;
      start2 = 1'b0;
   endtask

   task automatic or_sequence();
      send_vec(1'b0, 1'b0, 1'b0); gap(4);
      send_vec(1'b0, 1'b1, 1'b1); gap(4);
      send_vec(1'b1, 1'b0, 1'b1); gap(4);
      send_vec(1'b1, 1'b1, 1'b1);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n    = 1'b0;
      start0   = 1'b0;
      start1   = 1'b0;
      start2   = 1'b0;
      tb_valid = 1'b0;
      tb_a     = 1'b0;
      tb_b     = 1'b0;
      tb_c     = 1'b0;
      gap(2);

      // Reset state
      check("rst_ready", 32'(if0.in_ready), 0);
      check("rst_busy",  32'(busy0), 0);
      check("rst_done",  32'(done0), 0);
      check("rst_pass",  32'(pass0), 0);
      check("rst_err",   32'(err0), 0);
      check("rst_vec",   32'(vec0), 0);
      check("rst_cov",   32'(cov0), 0);
      rst_n = 1'b1;
      gap(1);

      // Samples before start are dropped
      tb_valid = 1'b1; tb_a = 1'b0; tb_b = 1'b0; tb_c = 1'b1;
      gap(3);
      tb_valid = 1'b0;
      check("idle_ready", 32'(if0.in_ready), 0);
      check("idle_vec",   32'(vec0), 0);
      check("idle_err",   32'(err0), 0);

      // OR reference run
      pulse_start(0);
      check("run_busy",  32'(busy0), 1);
      check("run_ready", 32'(if0.in_ready), 1);
      send_vec(1'b0, 1'b0, 1'b0); gap(4);
      check("or_vec1", 32'(vec0), 1);
      check("or_cov1", 32'(cov0), 32'h1);
      send_vec(1'b0, 1'b1, 1'b1); gap(4);
      pulse_start(0);
      check("run_start_ignored_vec", 32'(vec0), 2);
      check("run_start_ignored_cov", 32'(cov0), 32'h3);
      send_vec(1'b1, 1'b0, 1'b1); gap(4);
      check("or_done_before_last", 32'(done0), 0);
      send_vec(1'b1, 1'b1, 1'b1);
      check("or_done",  32'(done0), 1);
      check("or_busy",  32'(busy0), 0);
      check("or_ready", 32'(if0.in_ready), 0);
      check("or_err",   32'(err0), 0);
      check("or_vec",   32'(vec0), 4);
      check("or_cov",   32'(cov0), 32'hF);
      check("or_pass",  32'(pass0), 1);
`ifdef GATE_RESP_FIRST_ERR_EN
      check("or_fev", 32'(fev0), 0);
`endif

      // Samples after done are dropped
      tb_valid = 1'b1; tb_a = 1'b0; tb_b = 1'b0; tb_c = 1'b1;
      gap(3);
      tb_valid = 1'b0;
      check("done_hold_vec", 32'(vec0), 4);
      check("done_hold_err", 32'(err0), 0);
      check("done_hold_done", 32'(done0), 1);

      // Faulty gate: c stuck at 0
      pulse_start(0);
      check("restart_vec",  32'(vec0), 0);
      check("restart_cov",  32'(cov0), 0);
      check("restart_pass", 32'(pass0), 0);
      send_vec(1'b0, 1'b0, 1'b0);
      send_vec(1'b0, 1'b1, 1'b0);
      send_vec(1'b1, 1'b0, 1'b0);
      send_vec(1'b1, 1'b1, 1'b0);
      check("fault_done", 32'(done0), 1);
      check("fault_err",  32'(err0), 3);
      check("fault_cov",  32'(cov0), 32'hF);
      check("fault_pass", 32'(pass0), 0);
`ifdef GATE_RESP_FIRST_ERR_EN
      check("fault_fev", 32'(fev0), 1);
      check("fault_fe",  32'(fe0), 32'h2);
      pulse_start(0);
      check("fe_clear_vld", 32'(fev0), 0);
      check("fe_clear",     32'(fe0), 0);
      or_sequence();
      check("fe_or_pass", 32'(pass0), 1);
`endif

      // Incomplete coverage on AND checker
      pulse_start(1);
      repeat (4) send_vec(1'b1, 1'b1, 1'b1);
      check("and_done", 32'(done1), 1);
      check("and_err",  32'(err1), 0);
      check("and_cov",  32'(cov1), 32'h8);
      check("and_pass", 32'(pass1), 0);

      // Saturation, 2-bit counters
      pulse_start(2);
      repeat (3) send_vec(1'b0, 1'b0, 1'b1);
      check("sat_done", 32'(done2), 1);
      check("sat_err",  32'(err2), 3);
      check("sat_vec",  32'(vec2), 3);
      check("sat_pass", 32'(pass2), 0);
      pulse_start(2);
      check("sat_restart_err", 32'(err2), 0);
      check("sat_restart_vec", 32'(vec2), 0);
      repeat (2) send_vec(1'b0, 1'b0, 1'b1);
      check("sat_two_err",  32'(err2), 2);
      check("sat_two_busy", 32'(busy2), 1);
      send_vec(1'b0, 1'b0, 1'b1);
      check("sat_final_err", 32'(err2), 3);

      // Reset mid-run
      pulse_start(0);
      send_vec(1'b0, 1'b0, 1'b0);
      send_vec(1'b0, 1'b1, 1'b1);
      check("mid_vec", 32'(vec0), 2);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy",  32'(busy0), 0);
      check("mid_rst_ready", 32'(if0.in_ready), 0);
      check("mid_rst_vec",   32'(vec0), 0);
      check("mid_rst_cov",   32'(cov0), 0);
      check("mid_rst_err2",  32'(err2), 0);
      gap(1);
      rst_n = 1'b1;
      gap(1);
      pulse_start(0);
      or_sequence();
      check("post_rst_done", 32'(done0), 1);
      check("post_rst_vec",  32'(vec0), 4);
      check("post_rst_pass", 32'(pass0), 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
